// File: rtl/drum_pkg.sv
// drum_pkg: command encodings and shared types for the drum trigger block.
package drum_pkg;

  typedef logic [7:0] cmd_t;

  localparam cmd_t CMD_KICK = 8'h02;
  localparam cmd_t CMD_CAL  = 8'h80;
  localparam cmd_t CMD_INT1 = 8'h01;
  localparam cmd_t CMD_INT2 = 8'h03;

  // Read-out handshake: ACTIVE is exactly "mcu_done high"; RELEASE waits for
  // mcu_load to return low before another byte may be offered.
  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_ACTIVE  = 2'd1,
    TX_RELEASE = 2'd2
  } tx_state_e;

  // Source slots of the enqueue arbiter, in priority order.
  localparam int SRC_KICK = 0;
  localparam int SRC_CAL  = 1;
  localparam int SRC_INT1 = 2;
  localparam int SRC_INT2 = 3;
  localparam int N_SRC    = 4;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stability counter and one-cycle press
// pulse for an active-low asynchronous push button.
module btn_debounce
  import drum_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Synchronize the raw button; idle level is released (high).
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the pre-edge value of its neighbours, as real hardware does.
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], btn_n_i};
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing
  // samples; a debounced high-to-low change is one press.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
        press_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/drum_trigger_top_integrated.sv
// drum_trigger_top_integrated: debounced buttons -> command FIFO -> DONE/LOAD
// handshaked SPI mode-0 read-out to the MCU; also idles the BNO085 SPI ports,
// sequences the sensor reset and drives the status LEDs.
// Optional build macro SENSOR_INT_TRIGGER_EN: falling edges of int1/int2
// enqueue CMD_INT1/CMD_INT2 once the sensor is initialized.
module drum_trigger_top_integrated
  import drum_pkg::*;
#(
  parameter int CLK_HZ           = 12_000_000,
  parameter int DEBOUNCE_CYCLES  = 64,
  parameter int RST_HOLD_CYCLES  = 1024,
  parameter int HEARTBEAT_CYCLES = CLK_HZ / 2,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic clk,
  input  logic fpga_rst_n,
  input  logic mcu_sck,
  input  logic mcu_sdi,
  output logic mcu_sdo,
  input  logic mcu_load,
  output logic mcu_done,
  output logic sclk,
  output logic mosi,
  output logic bno085_rst_n,
  input  logic miso1,
  input  logic miso2,
  output logic cs_n1,
  output logic cs_n2,
  input  logic int1,
  input  logic int2,
  input  logic calibrate_btn_n,
  input  logic kick_btn_n,
  output logic led_initialized,
  output logic led_error,
  output logic led_heartbeat
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RST_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int HB_W  = $clog2(HEARTBEAT_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_HOLD_CYCLES - 1);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HEARTBEAT_CYCLES - 1);

  // ---------------------------------------------------------------- inputs
  logic       kick_press, cal_press;
  logic [2:0] sck_sync_q, load_sync_q;   // [1] synchronized, [2] previous
  logic       sck_rise, sck_fall, load_rise, load_low;
  logic [N_SRC-1:0] src_set;
  logic       unused_inputs;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_kick_db (
    .clk     (clk),
    .rst_n   (fpga_rst_n),
    .btn_n_i (kick_btn_n),
    .press_o (kick_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cal_db (
    .clk     (clk),
    .rst_n   (fpga_rst_n),
    .btn_n_i (calibrate_btn_n),
    .press_o (cal_press)
  );

  // Synchronize MCU clock and load, keeping one extra stage for edge detect.
  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      sck_sync_q  <= '0;
      load_sync_q <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], mcu_sck};
      load_sync_q <= {load_sync_q[1:0], mcu_load};
    end
  end

  assign sck_rise  =  sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall  = ~sck_sync_q[1] &  sck_sync_q[2];
  assign load_rise =  load_sync_q[1] & ~load_sync_q[2];
  assign load_low  = ~load_sync_q[1];

  assign src_set[SRC_KICK] = kick_press;
  assign src_set[SRC_CAL]  = cal_press;

  logic init_q;

`ifdef SENSOR_INT_TRIGGER_EN
  logic [2:0] int1_sync_q, int2_sync_q;

  // Synchronize the active-low sensor interrupts for falling-edge detect.
  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      int1_sync_q <= '1;
      int2_sync_q <= '1;
    end else begin
      int1_sync_q <= {int1_sync_q[1:0], int1};
      int2_sync_q <= {int2_sync_q[1:0], int2};
    end
  end

  assign src_set[SRC_INT1] = int1_sync_q[2] & ~int1_sync_q[1] & init_q;
  assign src_set[SRC_INT2] = int2_sync_q[2] & ~int2_sync_q[1] & init_q;
  assign unused_inputs     = ^{mcu_sdi, miso1, miso2, CLK_HZ[0]};
`else
  assign src_set[SRC_INT1] = 1'b0;
  assign src_set[SRC_INT2] = 1'b0;
  assign unused_inputs     = ^{mcu_sdi, miso1, miso2, int1, int2, CLK_HZ[0]};
`endif

  // ------------------------------------------------------------ arbitration
  logic [N_SRC-1:0] pend_q, pend_d, pend_clr;
  logic             wr_req, fifo_wr, overflow;
  cmd_t             wr_data;
  logic             fifo_full, fifo_empty;

  // Pick one pending source per cycle, kick > calibrate > int1 > int2.
  always_comb begin
    wr_req   = 1'b0;
    wr_data  = CMD_KICK;
    pend_clr = '0;
    if (pend_q[SRC_KICK]) begin
      wr_req = 1'b1; wr_data = CMD_KICK; pend_clr[SRC_KICK] = 1'b1;
    end else if (pend_q[SRC_CAL]) begin
      wr_req = 1'b1; wr_data = CMD_CAL;  pend_clr[SRC_CAL]  = 1'b1;
    end else if (pend_q[SRC_INT1]) begin
      wr_req = 1'b1; wr_data = CMD_INT1; pend_clr[SRC_INT1] = 1'b1;
    end else if (pend_q[SRC_INT2]) begin
      wr_req = 1'b1; wr_data = CMD_INT2; pend_clr[SRC_INT2] = 1'b1;
    end
  end

  // A new event wins over the clear of the same slot so none is lost.
  assign pend_d   = (pend_q & ~pend_clr) | src_set;
  assign fifo_wr  = wr_req & ~fifo_full;
  assign overflow = wr_req &  fifo_full;

  // Pending flags.
  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) pend_q <= '0;
    else             pend_q <= pend_d;
  end

  // ------------------------------------------------------------------- FIFO
  cmd_t         mem_q [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
  logic         pop;
  cmd_t         fifo_head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign fifo_head  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Command storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers define what is valid, so
    // clearing them on reset empties the queue without resetting the array.
    if (fifo_wr) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
  end

  // Read/write pointers with a wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ------------------------------------------------------- read-out FSM
  tx_state_e state_q, state_d;
  logic      start_tx, done_q;

  // Handshake state register; done is registered alongside it.
  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      state_q <= TX_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == TX_ACTIVE);
    end
  end

  // Offer a byte when the queue is non-empty; after a pop, wait for load low.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TX_IDLE:    if (!fifo_empty) state_d = TX_ACTIVE;
      TX_ACTIVE:  if (load_rise)   state_d = TX_RELEASE;
      TX_RELEASE: if (load_low)    state_d = fifo_empty ? TX_IDLE : TX_ACTIVE;
      default:                     state_d = TX_IDLE;
    endcase
  end

  // Strobes: freeze the head as done rises; pop on load edge while done.
  always_comb begin
    start_tx = (state_d == TX_ACTIVE) && (state_q != TX_ACTIVE);
    pop      = (state_q == TX_ACTIVE) && load_rise;
  end

  // ----------------------------------------------------- SPI shift datapath
  cmd_t     tx_q, tx_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic     tx_exh_q, tx_exh_d;
  logic     sck_armed_q, sck_armed_d;

  // Step the bit index on each falling SCK that follows a rising one; stop
  // (no wrap) after bit 0 has been shifted out.
  always_comb begin
    tx_d        = tx_q;
    bit_idx_d   = bit_idx_q;
    tx_exh_d    = tx_exh_q;
    sck_armed_d = sck_armed_q;
    if (start_tx) begin
      tx_d        = fifo_head;
      bit_idx_d   = 3'd7;
      tx_exh_d    = 1'b0;
      sck_armed_d = 1'b0;
    end else if (state_q == TX_ACTIVE) begin
      if (sck_rise) begin
        sck_armed_d = 1'b1;
      end else if (sck_fall && sck_armed_q) begin
        sck_armed_d = 1'b0;
        if (bit_idx_q == 3'd0) tx_exh_d  = 1'b1;
        else                   bit_idx_d = bit_idx_q - 3'd1;
      end
    end
  end

  // Shift datapath registers.
  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      tx_q        <= '0;
      bit_idx_q   <= '0;
      tx_exh_q    <= 1'b0;
      sck_armed_q <= 1'b0;
    end else begin
      tx_q        <= tx_d;
      bit_idx_q   <= bit_idx_d;
      tx_exh_q    <= tx_exh_d;
      sck_armed_q <= sck_armed_d;
    end
  end

  assign mcu_sdo  = done_q & ~tx_exh_q & tx_q[bit_idx_q];
  assign mcu_done = done_q;

  // -------------------------------------------- sensor reset and LEDs
  logic [RST_W-1:0] rst_cnt_q;
  logic [HB_W-1:0]  hb_cnt_q;
  logic             hb_q, err_q;

  // Hold the sensor in reset for RST_HOLD_CYCLES, then release for good.
  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      rst_cnt_q <= '0;
      init_q    <= 1'b0;
    end else if (!init_q) begin
      if (rst_cnt_q == RST_LAST) init_q    <= 1'b1;
      else                       rst_cnt_q <= rst_cnt_q + 1'b1;
    end
  end

  // Heartbeat toggles every HEARTBEAT_CYCLES; error is sticky on a drop.
  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (hb_cnt_q == HB_LAST) begin
        hb_cnt_q <= '0;
        hb_q     <= ~hb_q;
      end else begin
        hb_cnt_q <= hb_cnt_q + 1'b1;
      end
      if (overflow) err_q <= 1'b1;
    end
  end

  assign bno085_rst_n    = init_q;
  assign led_initialized = init_q;
  assign led_heartbeat   = hb_q;
  assign led_error       = err_q;

  // Sensor SPI ports parked idle.
  assign sclk  = 1'b0;
  assign mosi  = 1'b0;
  assign cs_n1 = 1'b1;
  assign cs_n2 = 1'b1;

endmodule

// File: tb/tb_drum_trigger_top_integrated.sv
// tb_drum_trigger_top_integrated: directed bench for the drum trigger top
// (default build, SENSOR_INT_TRIGGER_EN undefined). Heartbeat period is
// shortened so its toggling can be checked within a short run.
module tb_drum_trigger_top_integrated;

  localparam int HB = 300;

  logic clk = 1'b0;
  logic fpga_rst_n;
  logic mcu_sck, mcu_sdi, mcu_sdo, mcu_load, mcu_done;
  logic sclk, mosi, bno085_rst_n, miso1, miso2, cs_n1, cs_n2, int1, int2;
  logic calibrate_btn_n, kick_btn_n;
  logic led_initialized, led_error, led_heartbeat;

  int n_tests = 0;
  int n_fail  = 0;

  // heartbeat monitor state
  int   cyc = 0;
  int   hb_toggles = 0;
  int   hb_bad = 0;
  logic hb_prev = 1'b0;

  always #5 clk = ~clk;

  drum_trigger_top_integrated #(
    .HEARTBEAT_CYCLES (HB)
  ) dut (
    .clk             (clk),
    .fpga_rst_n      (fpga_rst_n),
    .mcu_sck         (mcu_sck),
    .mcu_sdi         (mcu_sdi),
    .mcu_sdo         (mcu_sdo),
    .mcu_load        (mcu_load),
    .mcu_done        (mcu_done),
    .sclk            (sclk),
    .mosi            (mosi),
    .bno085_rst_n    (bno085_rst_n),
    .miso1           (miso1),
    .miso2           (miso2),
    .cs_n1           (cs_n1),
    .cs_n2           (cs_n2),
    .int1            (int1),
    .int2            (int2),
    .calibrate_btn_n (calibrate_btn_n),
    .kick_btn_n      (kick_btn_n),
    .led_initialized (led_initialized),
    .led_error       (led_error),
    .led_heartbeat   (led_heartbeat)
  );

  // clock edges since the last reset release
  always @(posedge clk) begin
    if (!fpga_rst_n) cyc <= 0;
    else             cyc <= cyc + 1;
  end

  // every heartbeat toggle must land on a multiple of HB edges
  always @(negedge clk) begin
    if (fpga_rst_n) begin
      if (led_heartbeat !== hb_prev) begin
        hb_toggles++;
        if (cyc % HB != 0) hb_bad++;
      end
    end else begin
      hb_toggles = 0;
    end
    hb_prev = led_heartbeat;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic kick, input logic cal);
    if (kick) kick_btn_n = 1'b0;
    if (cal)  calibrate_btn_n = 1'b0;
    repeat (200) @(negedge clk);
    kick_btn_n      = 1'b1;
    calibrate_btn_n = 1'b1;
    repeat (150) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (mcu_done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, mcu_done, 1);
  endtask

  // MCU side of SPI mode 0: sample on the rising edge, 12-clk SCK period
  task automatic sck_pulse(output logic bit_o);
    mcu_sck = 1'b1;
    bit_o   = mcu_sdo;
    repeat (6) @(negedge clk);
    mcu_sck = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic bv;
    b = '0;
    for (int i = 7; i >= 0; i--) begin
      sck_pulse(bv);
      b[i] = bv;
    end
  endtask

  task automatic do_load(input string tag);
    mcu_load = 1'b1;
    repeat (6) @(negedge clk);
    check(tag, mcu_done, 0);
    mcu_load = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic read_expect(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    wait_done({tag, "_done"});
    read_byte(b);
    check({tag, "_byte"}, b, exp);
    check({tag, "_sdo_end"}, mcu_sdo, 0);
    do_load({tag, "_pop"});
  endtask

  initial begin
    logic [7:0] b;
    logic       bv;
    fpga_rst_n      = 1'b0;
    mcu_sck         = 1'b0;
    mcu_sdi         = 1'b0;
    mcu_load        = 1'b0;
    miso1           = 1'b0;
    miso2           = 1'b0;
    int1            = 1'b1;
    int2            = 1'b1;
    kick_btn_n      = 1'b1;
    calibrate_btn_n = 1'b1;
    repeat (4) @(negedge clk);

    // reset state
    check("rst_sdo",     mcu_sdo, 0);
    check("rst_done",    mcu_done, 0);
    check("rst_sclk",    sclk, 0);
    check("rst_mosi",    mosi, 0);
    check("rst_cs",      {cs_n1, cs_n2}, 2'b11);
    check("rst_bno",     bno085_rst_n, 0);
    check("rst_leds",    {led_initialized, led_error, led_heartbeat}, 3'b000);

    // sensor reset sequencing
    fpga_rst_n = 1'b1;
    repeat (1023) @(negedge clk);
    check("bno_hold",    bno085_rst_n, 0);
    check("init_hold",   led_initialized, 0);
    @(negedge clk);
    check("bno_release", bno085_rst_n, 1);
    check("init_set",    led_initialized, 1);
    check("idle_cs",     {cs_n1, cs_n2, sclk}, 3'b110);
    check("idle_done",   mcu_done, 0);
    check("idle_err",    led_error, 0);

    // first kick, with extra SCK pulse after the byte (no wrap)
    press(1'b1, 1'b0);
    wait_done("kick1_done");
    read_byte(b);
    check("kick1_byte", b, 8'h02);
    check("kick1_sdo_end", mcu_sdo, 0);
    sck_pulse(bv);
    check("kick1_no_wrap", bv, 0);
    do_load("kick1_pop");
    repeat (100) @(negedge clk);
    check("kick1_release_quiet", mcu_done, 0);

    // second kick
    press(1'b1, 1'b0);
    read_expect("kick2", 8'h02);

    // bouncing contact: no accepted low shorter than 64 samples
    kick_btn_n = 1'b0; repeat (20) @(negedge clk);
    kick_btn_n = 1'b1; repeat (15) @(negedge clk);
    kick_btn_n = 1'b0; repeat (40) @(negedge clk);
    kick_btn_n = 1'b1; repeat (10) @(negedge clk);
    kick_btn_n = 1'b0; repeat (50) @(negedge clk);
    kick_btn_n = 1'b1; repeat (5)  @(negedge clk);
    check("bounce_no_early", mcu_done, 0);
    press(1'b1, 1'b0);
    read_expect("bounce", 8'h02);
    repeat (100) @(negedge clk);
    check("bounce_single", mcu_done, 0);

    // calibrate
    press(1'b0, 1'b1);
    read_expect("cal", 8'h80);

    // simultaneous presses: kick has priority
    press(1'b1, 1'b1);
    read_expect("both_first", 8'h02);
    read_expect("both_second", 8'h80);
    repeat (100) @(negedge clk);
    check("both_empty", mcu_done, 0);

    // overflow: five presses into a four-deep queue
    check("ovf_err_before", led_error, 0);
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
    check("ovf_err_set", led_error, 1);
    for (int i = 0; i < 4; i++) read_expect($sformatf("ovf%0d", i), 8'h02);
    repeat (100) @(negedge clk);
    check("ovf_only_four", mcu_done, 0);
    check("ovf_err_sticky", led_error, 1);
    check("hb_count_pre", hb_toggles, cyc / HB);

    // reset in the middle of a transfer discards it
    press(1'b1, 1'b0);
    wait_done("mid_done");
    sck_pulse(bv);
    fpga_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_done", mcu_done, 0);
    check("mid_rst_err",  led_error, 0);
    check("mid_rst_bno",  bno085_rst_n, 0);
    fpga_rst_n = 1'b1;
    repeat (1100) @(negedge clk);
    check("mid_rst_init",  led_initialized, 1);
    check("mid_rst_empty", mcu_done, 0);

    // heartbeat: toggle count and spacing since the last release
    #2;
    check("hb_count",    hb_toggles, cyc / HB);
    check("hb_interval", hb_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/drum_trigger_top_integrated.md
Name: drum_trigger_top_integrated

Overview:
Top-level FPGA block for the drum trigger system. It debounces the kick and calibrate buttons and turns each press into a one-byte drum command. Commands queue in a small FIFO and are handed to the MCU over a DONE/LOAD-handshaked SPI read-out. It also holds the two BNO085 sensor SPI ports in a safe idle state, sequences the sensor reset, and drives the status LEDs.

Parameters:
- CLK_HZ, 12_000_000: clk frequency; f_clk must be at least 8× f_mcu_sck.
- DEBOUNCE_CYCLES, 64: number of consecutive stable synchronized samples needed to accept a button level.
- RST_HOLD_CYCLES, 1024: clk cycles bno085_rst_n is held low after reset release.
- HEARTBEAT_CYCLES, CLK_HZ/2: half-period of led_heartbeat.
- FIFO_DEPTH, 4: command queue depth; must be a power of 2.

Ports:
- clk in 1: system clock, the only clock domain.
- fpga_rst_n in 1: asynchronous active-low reset.
- mcu_sck in 1: MCU SPI clock, oversampled in clk.
- mcu_sdi in 1: MCU data in; ignored.
- mcu_sdo out 1: command bit to the MCU, MSB first.
- mcu_load in 1: MCU acknowledge (rising edge pops the current command).
- mcu_done out 1: high while a command byte is available.
- sclk, mosi out 1: BNO085 SPI clock and data; held 0.
- bno085_rst_n out 1: sensor reset, active low.
- miso1, miso2 in 1: sensor data; ignored.
- cs_n1, cs_n2 out 1: sensor chip selects; held 1.
- int1, int2 in 1: sensor interrupts, active low.
- calibrate_btn_n, kick_btn_n in 1: buttons, active low, asynchronous.
- led_initialized, led_error, led_heartbeat out 1: status LEDs.

Behaviour:
- Reset values: mcu_sdo=0, mcu_done=0, sclk=0, mosi=0, cs_n1=cs_n2=1, bno085_rst_n=0, all LEDs 0, FIFO empty.
- Input synchronization: every asynchronous input (buttons, mcu_sck, mcu_load, int1, int2) passes through a 2-FF synchronizer.
- Debounce: the debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples. A debounced high-to-low transition is one press and produces exactly one event; release produces nothing.
- Commands: kick press enqueues 0x02; calibrate press enqueues 0x80.
- Enqueue arbitration: each source has a pending flag. At most one byte is written per cycle, priority kick > calibrate > int1 > int2. A pending flag clears when its byte is written.
- FIFO full: the new byte is dropped and led_error is set; led_error is sticky until reset.
- mcu_done: registered; goes high the cycle after the FIFO becomes non-empty while no transfer is active. The FIFO head is frozen into a transmit register when done rises.
- SPI read-out, SPI mode 0:
  - When done rises, the bit index resets to 7 and mcu_sdo shows bit 7.
  - The MCU samples on mcu_sck rising edges.
  - On each synchronized mcu_sck falling edge that follows a rising edge, the index decrements.
  - After 8 falling edges mcu_sdo is held 0.
  - Extra SCK edges do not wrap.
- Pop: a synchronized mcu_load rising edge while done=1 pops the FIFO and drops done the next cycle. Done may re-assert only after mcu_load is seen low. A load edge while done=0 is ignored.
- Sensor reset: bno085_rst_n goes high after RST_HOLD_CYCLES; led_initialized goes high in the same cycle and stays high.
- Heartbeat: led_heartbeat toggles every HEARTBEAT_CYCLES after reset.
- Reset mid-transfer: the FIFO and any partial transfer are discarded.

Optional Feature:
- SENSOR_INT_TRIGGER_EN defined: a synchronized falling edge of int1 enqueues 0x01, and of int2 enqueues 0x03. These use the same arbitration as the buttons and are gated by led_initialized.
- Not defined: int1 and int2 are ignored and the command set is 0x02 and 0x80 only.

Decomposition:
- Package drum_pkg: CMD_KICK=8'h02, CMD_CAL=8'h80, CMD_INT1=8'h01, CMD_INT2=8'h03, and a cmd_t 8-bit typedef.
- Sub-module btn_debounce: synchronizer, debounce counter and press-edge pulse. It is instantiated for each button.
- The FIFO, SPI read-out, sensor reset sequencing and LEDs stay in the top level.

Test Plan:
- Reset released, RST_HOLD_CYCLES elapse -> bno085_rst_n=1 and led_initialized=1; cs_n1=cs_n2=1, sclk=0, done=0, led_error=0.
- kick_btn_n low for 200 cycles -> done=1. The MCU gates 8 SCK pulses at 1 MHz with f_clk ≥ 8 MHz and reads bits 0,0,0,0,0,0,1,0 = 0x02. A load pulse then gives done=0.
- A second kick press after the load -> a second 0x02 is read and done clears again.
- Bounce: kick_btn_n toggling with periods under DEBOUNCE_CYCLES, then held low -> exactly one 0x02 is queued.
- Calibrate press -> 0x80 is read. Kick and calibrate pressed in the same cycle -> 0x02 is read first, then 0x80.
- 5 kick presses with no reads -> 4 bytes of 0x02 are readable and led_error=1. led_heartbeat toggles at the expected period throughout.
